// File: rtl/ipsxb_fft_peak_detect_if.sv
// FFT output stream bundle (valid/data/last/user, no backpressure) feeding the peak detector.
interface ipsxb_fft_peak_detect_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned USER_WIDTH = 16
);
   logic                      tvalid;
   logic [2*DATA_WIDTH-1:0]   tdata;
   logic                      tlast;
   logic [USER_WIDTH-1:0]     tuser;

   modport master (output tvalid, tdata, tlast, tuser);
   modport slave  (input  tvalid, tdata, tlast, tuser);
endinterface

// File: rtl/ipsxb_fft_peak_detect.sv
// Per-frame |X[k]|^2 peak finder with frame-length monitor on the FFT output stream.
// Optional per-frame energy output enabled by defining FFT_PEAK_ENERGY_EN.
module ipsxb_fft_peak_detect #(
   parameter int unsigned LOGS_FFT_LEN  = 10,
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned USER_WIDTH    = 16,
   parameter int unsigned HALF_SPECTRUM = 1,
   parameter int unsigned SKIP_DC       = 1
) (
   input  logic                        i_aclk,
   input  logic                        i_arst,
   input  logic                        i_aclken,
   ipsxb_fft_peak_detect_if.slave      i_axi4s_data,
   output logic                        o_peak_valid,
   output logic [LOGS_FFT_LEN-1:0]     o_peak_index,
   output logic [2*DATA_WIDTH-1:0]     o_peak_mag,
   output logic [4:0]                  o_peak_blk_exp,
   output logic                        o_frame_err,
   output logic [15:0]                 o_frame_cnt
`ifdef FFT_PEAK_ENERGY_EN
   ,
   output logic [2*DATA_WIDTH+LOGS_FFT_LEN-1:0] o_frame_energy
`endif
);

   localparam int unsigned N  = 1 << LOGS_FFT_LEN;
   localparam int unsigned PW = 2 * DATA_WIDTH;
   localparam int unsigned CW = LOGS_FFT_LEN + 1;
   localparam int unsigned LW = LOGS_FFT_LEN;
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(N);

   logic [LW-1:0]  in_idx;
   logic [4:0]     in_exp;
   logic           in_cand;
   logic           len_err;
   logic           unused_tuser;

   logic [CW-1:0]  beat_cnt;

   logic                          s1_vld, s1_last, s1_cand, s1_err;
   logic signed [DATA_WIDTH-1:0]  s1_re, s1_im;
   logic [LW-1:0]                 s1_idx;
   logic [4:0]                    s1_exp;

   logic                          s2_vld, s2_last, s2_cand, s2_err;
   logic signed [PW-1:0]          s2_rr, s2_ii;
   logic [LW-1:0]                 s2_idx;
   logic [4:0]                    s2_exp;

   logic                          s3_vld, s3_last, s3_cand, s3_err;
   logic [PW-1:0]                 s3_mag;
   logic [LW-1:0]                 s3_idx;
   logic [4:0]                    s3_exp;

   logic                          have_max;
   logic [PW-1:0]                 max_mag;
   logic [LW-1:0]                 max_idx;
   logic                          take;
   logic [PW-1:0]                 nxt_mag;
   logic [LW-1:0]                 nxt_idx;

   assign in_idx       = i_axi4s_data.tuser[LW-1:0];
   assign in_exp       = i_axi4s_data.tuser[LW+4:LW];
   assign unused_tuser = ^i_axi4s_data.tuser;

   // Candidate mask from the bin index carried in tuser
   always_comb begin
      in_cand = 1'b1;
      if ((HALF_SPECTRUM != 0) && in_idx[LW-1]) in_cand = 1'b0;
      if ((SKIP_DC != 0) && (in_idx == '0))     in_cand = 1'b0;
   end

   // Early tlast, or the N-th beat arriving without tlast
   always_comb begin
      len_err = 1'b0;
      if (i_axi4s_data.tlast) len_err = (beat_cnt != LAST_CNT);
      else                    len_err = (beat_cnt == LAST_CNT);
   end

   // S1: capture accepted beat and track frame length
   always_ff @(posedge i_aclk or posedge i_arst) begin
      if (i_arst) begin
         beat_cnt <= '0;
         s1_vld   <= 1'b0;
         s1_last  <= 1'b0;
         s1_cand  <= 1'b0;
         s1_err   <= 1'b0;
         s1_re    <= '0;
         s1_im    <= '0;
         s1_idx   <= '0;
         s1_exp   <= '0;
      end else if (i_aclken) begin
         s1_vld <= i_axi4s_data.tvalid;
         if (i_axi4s_data.tvalid) begin
            s1_re   <= i_axi4s_data.tdata[DATA_WIDTH-1:0];
            s1_im   <= i_axi4s_data.tdata[PW-1:DATA_WIDTH];
            s1_idx  <= in_idx;
            s1_exp  <= in_exp;
            s1_last <= i_axi4s_data.tlast;
            s1_cand <= in_cand;
            s1_err  <= len_err;
            if (i_axi4s_data.tlast)       beat_cnt <= '0;
            else if (beat_cnt != FULL_CNT) beat_cnt <= beat_cnt + CW'(1);
         end
      end
   end

   // S2: squares; S3: magnitude (2^(2W-1) worst case fits unsigned PW bits)
   always_ff @(posedge i_aclk or posedge i_arst) begin
      if (i_arst) begin
         s2_vld  <= 1'b0;
         s2_last <= 1'b0;
         s2_cand <= 1'b0;
         s2_err  <= 1'b0;
         s2_rr   <= '0;
         s2_ii   <= '0;
         s2_idx  <= '0;
         s2_exp  <= '0;
         s3_vld  <= 1'b0;
         s3_last <= 1'b0;
         s3_cand <= 1'b0;
         s3_err  <= 1'b0;
         s3_mag  <= '0;
         s3_idx  <= '0;
         s3_exp  <= '0;
      end else if (i_aclken) begin
         s2_vld  <= s1_vld;
         s2_last <= s1_last;
         s2_cand <= s1_cand;
         s2_err  <= s1_err;
         s2_rr   <= PW'(s1_re) * PW'(s1_re);
         s2_ii   <= PW'(s1_im) * PW'(s1_im);
         s2_idx  <= s1_idx;
         s2_exp  <= s1_exp;
         s3_vld  <= s2_vld;
         s3_last <= s2_last;
         s3_cand <= s2_cand;
         s3_err  <= s2_err;
         s3_mag  <= $unsigned(s2_rr) + $unsigned(s2_ii);
         s3_idx  <= s2_idx;
         s3_exp  <= s2_exp;
      end
   end

   // Strict compare keeps the earliest arrival on ties; first candidate always loads
   always_comb begin
      take    = s3_vld & s3_cand & (~have_max | (s3_mag > max_mag));
      nxt_mag = take ? s3_mag : max_mag;
      nxt_idx = take ? s3_idx : max_idx;
   end

   // S4: running max and frame close
   always_ff @(posedge i_aclk or posedge i_arst) begin
      if (i_arst) begin
         have_max       <= 1'b0;
         max_mag        <= '0;
         max_idx        <= '0;
         o_peak_valid   <= 1'b0;
         o_peak_index   <= '0;
         o_peak_mag     <= '0;
         o_peak_blk_exp <= '0;
         o_frame_err    <= 1'b0;
         o_frame_cnt    <= '0;
      end else if (i_aclken) begin
         o_peak_valid <= 1'b0;
         o_frame_err  <= 1'b0;
         if (s3_vld) begin
            o_frame_err <= s3_err;
            if (s3_last) begin
               o_peak_valid   <= 1'b1;
               o_peak_index   <= nxt_idx;
               o_peak_mag     <= nxt_mag;
               o_peak_blk_exp <= s3_exp;
               o_frame_cnt    <= o_frame_cnt + 16'd1;
               have_max       <= 1'b0;
               max_mag        <= '0;
               max_idx        <= '0;
            end else if (take) begin
               have_max <= 1'b1;
               max_mag  <= s3_mag;
               max_idx  <= s3_idx;
            end
         end
      end
   end

`ifdef FFT_PEAK_ENERGY_EN
   localparam int unsigned EW = PW + LOGS_FFT_LEN;
   logic [EW-1:0] energy_acc;

   // Unmasked energy over every beat of the frame
   always_ff @(posedge i_aclk or posedge i_arst) begin
      if (i_arst) begin
         energy_acc     <= '0;
         o_frame_energy <= '0;
      end else if (i_aclken && s3_vld) begin
         if (s3_last) begin
            o_frame_energy <= energy_acc + EW'(s3_mag);
            energy_acc     <= '0;
         end else begin
            energy_acc <= energy_acc + EW'(s3_mag);
         end
      end
   end
`endif

endmodule

// File: tb/tb_ipsxb_fft_peak_detect.sv
// Scoreboard bench for ipsxb_fft_peak_detect with N=16, HALF_SPECTRUM=1, SKIP_DC=1.
module tb_ipsxb_fft_peak_detect;

   localparam int unsigned LOGS = 4;
   localparam int unsigned N    = 16;
   localparam int unsigned W    = 16;
   localparam int unsigned UW   = 16;

   typedef struct packed {
      logic [3:0]  idx;
      logic [31:0] mag;
      logic [4:0]  bexp;
      logic        err;
      logic [15:0] cnt;
      logic [35:0] energy;
   } res_t;

   logic clk = 1'b0;
   logic arst;
   logic aclken;
   always #5 clk = ~clk;

   ipsxb_fft_peak_detect_if #(.DATA_WIDTH(W), .USER_WIDTH(UW)) axis ();

   logic        o_peak_valid;
   logic [3:0]  o_peak_index;
   logic [31:0] o_peak_mag;
   logic [4:0]  o_peak_blk_exp;
   logic        o_frame_err;
   logic [15:0] o_frame_cnt;
`ifdef FFT_PEAK_ENERGY_EN
   logic [35:0] o_frame_energy;
`endif

   ipsxb_fft_peak_detect #(
      .LOGS_FFT_LEN(LOGS), .DATA_WIDTH(W), .USER_WIDTH(UW),
      .HALF_SPECTRUM(1), .SKIP_DC(1)
   ) dut (
      .i_aclk(clk),
      .i_arst(arst),
      .i_aclken(aclken),
      .i_axi4s_data(axis),
      .o_peak_valid(o_peak_valid),
      .o_peak_index(o_peak_index),
      .o_peak_mag(o_peak_mag),
      .o_peak_blk_exp(o_peak_blk_exp),
      .o_frame_err(o_frame_err),
      .o_frame_cnt(o_frame_cnt)
`ifdef FFT_PEAK_ENERGY_EN
      ,
      .o_frame_energy(o_frame_energy)
`endif
   );

   res_t exp_q[$];
   res_t obs_q[$];
   res_t mon_r;
   res_t e, o;
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;
   bit   en_edge = 1'b0;
   int   err_only = 0;
   int   exp_err_only = 0;
   int   model_cnt = 0;
   int   last_drive_cyc = 0;
   int   last_valid_cyc = 0;

   int fr_re[64];
   int fr_im[64];
   int fr_idx[64];
   int fr_n;
   int fr_exp;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      en_edge <= aclken;
   end

   // Capture each fresh result pulse (only after an enabled edge)
   always @(negedge clk) begin
      if (en_edge && !arst) begin
         if (o_peak_valid) begin
            mon_r.idx  = o_peak_index;
            mon_r.mag  = o_peak_mag;
            mon_r.bexp = o_peak_blk_exp;
            mon_r.err  = o_frame_err;
            mon_r.cnt  = o_frame_cnt;
`ifdef FFT_PEAK_ENERGY_EN
            mon_r.energy = o_frame_energy;
`else
            mon_r.energy = '0;
`endif
            obs_q.push_back(mon_r);
            last_valid_cyc = cyc;
         end else if (o_frame_err) begin
            err_only++;
         end
      end
   end

   function automatic int bitrev4(input int x);
      int r = 0;
      for (int i = 0; i < 4; i++) if (((x >> i) & 1) != 0) r |= (1 << (3 - i));
      return r;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         aclken = 1'b1;
         axis.tvalid = 1'b0;
         axis.tlast  = 1'b0;
      end
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      arst = 1'b1;
      aclken = 1'b0;
      axis.tvalid = 1'b0;
      axis.tlast  = 1'b0;
      repeat (3) @(posedge clk);
      #1 arst = 1'b0;
      model_cnt = 0;
      exp_q.delete();
      obs_q.delete();
      err_only = 0;
      exp_err_only = 0;
   endtask

   task automatic clear_frame(input int n, input int bexp);
      fr_n = n;
      fr_exp = bexp;
      for (int b = 0; b < 64; b++) begin
         fr_re[b]  = 0;
         fr_im[b]  = 0;
         fr_idx[b] = b % N;
      end
   endtask

   // Drives nsend beats of the staged frame; when push is set the model result is queued
   task automatic send_frame(input bit toggle, input bit push, input int nsend);
      longint m, bm, en;
      int     bi;
      bit     have, cand;
      res_t   r;
      if (push) begin
         have = 0; bm = 0; bi = 0; en = 0;
         for (int b = 0; b < fr_n; b++) begin
            m = longint'(fr_re[b]) * longint'(fr_re[b]) + longint'(fr_im[b]) * longint'(fr_im[b]);
            en += m;
            cand = (fr_idx[b] < int'(N / 2)) && (fr_idx[b] != 0);
            if (cand && (!have || m > bm)) begin
               have = 1; bm = m; bi = fr_idx[b];
            end
         end
         model_cnt++;
         r.idx  = 4'(bi);
         r.mag  = 32'(bm);
         r.bexp = 5'(fr_exp);
         r.err  = (fr_n != int'(N));
         r.cnt  = 16'(model_cnt);
`ifdef FFT_PEAK_ENERGY_EN
         r.energy = 36'(en);
`else
         r.energy = '0;
`endif
         exp_q.push_back(r);
         if (fr_n > int'(N)) exp_err_only++;
      end
      for (int b = 0; b < nsend; b++) begin
         @(posedge clk); #1;
         aclken      = 1'b1;
         axis.tvalid = 1'b1;
         axis.tdata  = {16'(fr_im[b]), 16'(fr_re[b])};
         axis.tuser  = UW'({5'(fr_exp), 4'(fr_idx[b])});
         axis.tlast  = (b == fr_n - 1);
         last_drive_cyc = cyc;
         if (toggle) begin
            @(posedge clk); #1;
            aclken = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      n_vec++; if (o_peak_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", o_peak_valid); end
      n_vec++; if (o_peak_index !== 4'd0) begin n_bad++; $display("FAIL reset_index got %0d want 0", o_peak_index); end
      n_vec++; if (o_peak_mag !== 32'd0) begin n_bad++; $display("FAIL reset_mag got %h want 0", o_peak_mag); end
      n_vec++; if (o_peak_blk_exp !== 5'd0) begin n_bad++; $display("FAIL reset_blk_exp got %0d want 0", o_peak_blk_exp); end
      n_vec++; if (o_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", o_frame_err); end
      n_vec++; if (o_frame_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", o_frame_cnt); end
`ifdef FFT_PEAK_ENERGY_EN
      n_vec++; if (o_frame_energy !== 36'd0) begin n_bad++; $display("FAIL reset_energy got %h want 0", o_frame_energy); end
`endif
   endtask

   task automatic test_tone();
      clear_frame(N, 5);
      fr_re[3] = 1000;
      send_frame(0, 1, N);
      for (int t = 0; t < 200 && obs_q.size() < exp_q.size(); t++) idle(1);
      idle(2);
      n_vec++; if (last_valid_cyc - last_drive_cyc !== 4) begin n_bad++; $display("FAIL tone_latency got %0d want 4", last_valid_cyc - last_drive_cyc); end
      n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL tone_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_vec++; if (o !== e) begin n_bad++; $display("FAIL tone_result got %h want %h", o, e); end
      end
      n_vec++; if (o.mag !== 32'd1000000 || o.idx !== 4'd3) begin n_bad++; $display("FAIL tone_abs got idx=%0d mag=%0d want idx=3 mag=1000000", o.idx, o.mag); end
   endtask

   task automatic test_tie();
      clear_frame(N, 2);
      for (int b = 1; b < 8; b++) begin fr_re[b] = 3; fr_im[b] = 4; end
      fr_re[2] = 20; fr_im[2] = 10;
      fr_re[5] = 10; fr_im[5] = 20;
      send_frame(0, 1, N);
      for (int t = 0; t < 200 && obs_q.size() < exp_q.size(); t++) idle(1);
      idle(2);
      n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL tie_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_vec++; if (o !== e) begin n_bad++; $display("FAIL tie_result got %h want %h", o, e); end
      end
   endtask

   task automatic test_mask();
      clear_frame(N, 9);
      fr_re[0]  = 30000;
      fr_re[12] = 20000;
      fr_re[4]  = 100;
      send_frame(0, 1, N);
      for (int t = 0; t < 200 && obs_q.size() < exp_q.size(); t++) idle(1);
      idle(2);
      n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL mask_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_vec++; if (o !== e) begin n_bad++; $display("FAIL mask_result got %h want %h", o, e); end
      end
   endtask

   task automatic test_short_frame();
      apply_reset();
      clear_frame(10, 1);
      fr_re[6] = 700; fr_im[6] = -300;
      send_frame(0, 1, 10);
      clear_frame(N, 3);
      for (int b = 0; b < int'(N); b++) begin fr_re[b] = b * 11; fr_im[b] = -b * 7; end
      send_frame(0, 1, N);
      for (int t = 0; t < 200 && obs_q.size() < exp_q.size(); t++) idle(1);
      idle(2);
      n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL short_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_vec++; if (o !== e) begin n_bad++; $display("FAIL short_result got %h want %h", o, e); end
      end
      n_vec++; if (o_frame_cnt !== 16'd2) begin n_bad++; $display("FAIL short_frame_cnt got %0d want 2", o_frame_cnt); end
   endtask

   task automatic test_overrun();
      clear_frame(18, 4);
      for (int b = 0; b < 18; b++) fr_re[b] = 50 + b;
      send_frame(0, 1, 18);
      for (int t = 0; t < 200 && obs_q.size() < exp_q.size(); t++) idle(1);
      idle(2);
      n_vec++; if (err_only != exp_err_only) begin n_bad++; $display("FAIL overrun_err_pulses got %0d want %0d", err_only, exp_err_only); end
      n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL overrun_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_vec++; if (o !== e) begin n_bad++; $display("FAIL overrun_result got %h want %h", o, e); end
      end
   endtask

   task automatic test_back_to_back();
      clear_frame(N, 7);
      fr_re[1] = -32768; fr_im[1] = -32768;
      fr_re[2] = 32767;  fr_im[2] = 32767;
      send_frame(1, 1, N);
      clear_frame(N, 11);
      fr_re[1] = 12;     fr_im[1] = 5;
      fr_re[7] = -32768; fr_im[7] = -32768;
      send_frame(1, 1, N);
      for (int t = 0; t < 200 && obs_q.size() < exp_q.size(); t++) idle(1);
      idle(2);
      n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_vec++; if (o !== e) begin n_bad++; $display("FAIL b2b_result got %h want %h", o, e); end
      end
      n_vec++; if (o.mag !== 32'h8000_0000) begin n_bad++; $display("FAIL b2b_full_scale got %h want 80000000", o.mag); end
   endtask

   task automatic test_reset_mid_frame();
      clear_frame(N, 6);
      for (int b = 0; b < int'(N); b++) fr_re[b] = 900 + b;
      send_frame(0, 0, 9);
      apply_reset();
      clear_frame(N, 13);
      for (int b = 0; b < int'(N); b++) begin fr_re[b] = (b * 37) % 200 - 100; fr_im[b] = b * 3; end
      send_frame(0, 1, N);
      for (int t = 0; t < 200 && obs_q.size() < exp_q.size(); t++) idle(1);
      idle(4);
      n_vec++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL midrst_count got %0d want 1", obs_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_vec++; if (o !== e) begin n_bad++; $display("FAIL midrst_result got %h want %h", o, e); end
      end
   endtask

   task automatic test_random_bitrev();
      for (int f = 0; f < 3; f++) begin
         clear_frame(N, f + 20);
         for (int b = 0; b < int'(N); b++) begin
            fr_idx[b] = bitrev4(b);
            fr_re[b]  = int'($urandom_range(65535)) - 32768;
            fr_im[b]  = int'($urandom_range(65535)) - 32768;
         end
         send_frame(f == 1, 1, N);
      end
      for (int t = 0; t < 300 && obs_q.size() < exp_q.size(); t++) idle(1);
      idle(2);
      n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_vec++; if (o !== e) begin n_bad++; $display("FAIL random_result got %h want %h", o, e); end
      end
   endtask

   initial begin
      arst = 1'b1;
      aclken = 1'b0;
      axis.tvalid = 1'b0;
      axis.tdata  = '0;
      axis.tlast  = 1'b0;
      axis.tuser  = '0;
      test_reset();
      test_tone();
      test_tie();
      test_mask();
      test_short_frame();
      test_overrun();
      test_back_to_back();
      test_reset_mid_frame();
      test_random_bitrev();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
